// File: rtl/axi_lite_isolation_controller.sv
// Isolation sequencer for one AXI-Lite slave region: tracks outstanding
// transactions, drains or forces decoupling, and re-couples on software ack.
module axi_lite_isolation_controller #(
    parameter int unsigned OUTSTANDING_WREQ     = 8,
    parameter int unsigned OUTSTANDING_RREQ     = 8,
    parameter int unsigned DRAIN_TIMEOUT_CYCLES = 255,
    localparam int unsigned WCNT_W  = $clog2(OUTSTANDING_WREQ + 1),
    localparam int unsigned RCNT_W  = $clog2(OUTSTANDING_RREQ + 1),
    localparam int unsigned DRAIN_W = $clog2(DRAIN_TIMEOUT_CYCLES + 2)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              i_mon_awvalid,
    input  logic              i_mon_awready,
    input  logic              i_mon_wvalid,
    input  logic              i_mon_wready,
    input  logic              i_mon_bvalid,
    input  logic              i_mon_bready,
    input  logic              i_mon_arvalid,
    input  logic              i_mon_arready,
    input  logic              i_mon_rvalid,
    input  logic              i_mon_rready,
    input  logic              i_sw_decouple_req,
    input  logic              i_sw_recouple,
    input  logic              i_timeout_error_irq,
    output logic              o_timeout_error_clear,
    output logic              o_block_aw,
    output logic              o_block_w,
    output logic              o_block_ar,
    output logic              o_decouple,
    output logic              o_decouple_force,
    output logic              o_decouple_done,
    output logic              o_bresp_expected,
    output logic              o_rresp_expected,
    output logic [1:0]        o_ctrl_state,
    output logic [1:0]        o_force_cause,
    output logic [WCNT_W-1:0] o_aw_cnt,
    output logic [WCNT_W-1:0] o_w_cnt,
    output logic [RCNT_W-1:0] o_ar_cnt
);

    typedef enum logic [1:0] {
        ST_COUPLED   = 2'd0,
        ST_DRAINING  = 2'd1,
        ST_DECOUPLED = 2'd2,
        ST_FORCED    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WCNT_W-1:0]   r_aw_cnt;
    logic [WCNT_W-1:0]   r_w_cnt;
    logic [RCNT_W-1:0]   r_ar_cnt;
    logic [DRAIN_W-1:0]  r_drain;
    logic [1:0]          r_force_cause;
    logic [1:0]          w_cause_set;
    logic                r_irq_mask;
    logic                w_irq;
    logic                w_leave_forced;
    logic                w_cnt_zero;
    logic                w_hs_aw, w_hs_w, w_hs_b, w_hs_ar, w_hs_r;

    assign w_hs_aw = i_mon_awvalid & i_mon_awready;
    assign w_hs_w  = i_mon_wvalid  & i_mon_wready;
    assign w_hs_b  = i_mon_bvalid  & i_mon_bready;
    assign w_hs_ar = i_mon_arvalid & i_mon_arready;
    assign w_hs_r  = i_mon_rvalid  & i_mon_rready;

    // The verifier's irq stays high for a cycle after it is cleared
    assign w_irq          = i_timeout_error_irq & ~r_irq_mask;
    assign w_cnt_zero     = (r_aw_cnt == '0) && (r_w_cnt == '0) && (r_ar_cnt == '0);
    assign w_leave_forced = (r_state == ST_FORCED) && (w_state_nxt != ST_FORCED);

    // Saturating up/down count; simultaneous inc and dec cancel
    function automatic int unsigned cnt_next(input int unsigned cnt, input logic inc,
                                             input logic dec, input int unsigned max);
        if (inc && !dec && (cnt < max)) return cnt + 1;
        if (dec && !inc && (cnt != 0))  return cnt - 1;
        return cnt;
    endfunction

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= ST_COUPLED;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic and force-cause capture
    always_comb begin
        w_state_nxt = r_state;
        w_cause_set = 2'b00;
        case (r_state)
            ST_COUPLED: begin
                if (w_irq) begin
                    w_state_nxt = ST_FORCED;
                    w_cause_set = 2'b01;
                end else if (i_sw_decouple_req) begin
                    w_state_nxt = ST_DRAINING;
                end
            end
            ST_DRAINING: begin
                if (w_irq) begin
                    w_state_nxt = ST_FORCED;
                    w_cause_set = 2'b01;
                end else if (w_cnt_zero) begin
                    w_state_nxt = ST_DECOUPLED;
                end else if (r_drain == DRAIN_W'(DRAIN_TIMEOUT_CYCLES)) begin
                    w_state_nxt = ST_FORCED;
                    w_cause_set = 2'b10;
                end
            end
            ST_DECOUPLED: begin
                if (w_irq) begin
                    w_state_nxt = ST_FORCED;
                    w_cause_set = 2'b01;
                end else if (!i_sw_decouple_req) begin
                    w_state_nxt = ST_COUPLED;
                end
            end
            ST_FORCED: begin
                if (i_sw_recouple) begin
                    w_state_nxt = i_sw_decouple_req ? ST_DECOUPLED : ST_COUPLED;
                end
            end
            default: w_state_nxt = ST_COUPLED;
        endcase
    end

    // Output decode from state, counters and the recouple pulse
    always_comb begin
        o_block_aw            = 1'b1;
        o_block_w             = 1'b1;
        o_block_ar            = 1'b1;
        o_decouple            = 1'b0;
        o_decouple_force      = 1'b0;
        o_decouple_done       = 1'b0;
        o_timeout_error_clear = 1'b0;
        case (r_state)
            ST_COUPLED: begin
                o_block_aw = (r_aw_cnt == WCNT_W'(OUTSTANDING_WREQ));
                o_block_w  = (r_w_cnt  == WCNT_W'(OUTSTANDING_WREQ));
                o_block_ar = (r_ar_cnt == RCNT_W'(OUTSTANDING_RREQ));
            end
            ST_DRAINING: begin
                o_block_aw = (r_aw_cnt >= r_w_cnt);
                o_block_w  = (r_w_cnt  >= r_aw_cnt);
                o_decouple = 1'b1;
            end
            ST_DECOUPLED: begin
                o_decouple      = 1'b1;
                o_decouple_done = 1'b1;
            end
            ST_FORCED: begin
                o_decouple            = 1'b1;
                o_decouple_force      = 1'b1;
                o_timeout_error_clear = aresetn & i_sw_recouple;
            end
            default: ;
        endcase
    end

    // Outstanding counters; zeroed on entry to and throughout FORCED
    always_ff @(posedge aclk) begin
        if (!aresetn || (w_state_nxt == ST_FORCED) || (r_state == ST_FORCED)) begin
            r_aw_cnt <= '0;
            r_w_cnt  <= '0;
            r_ar_cnt <= '0;
        end else begin
            r_aw_cnt <= WCNT_W'(cnt_next(32'(r_aw_cnt), w_hs_aw, w_hs_b, OUTSTANDING_WREQ));
            r_w_cnt  <= WCNT_W'(cnt_next(32'(r_w_cnt),  w_hs_w,  w_hs_b, OUTSTANDING_WREQ));
            r_ar_cnt <= RCNT_W'(cnt_next(32'(r_ar_cnt), w_hs_ar, w_hs_r, OUTSTANDING_RREQ));
        end
    end

    // Drain timer: restarts while coupled, saturates past the timeout value
    always_ff @(posedge aclk) begin
        if (!aresetn || (r_state == ST_COUPLED)) begin
            r_drain <= '0;
        end else if ((r_state == ST_DRAINING) && (r_drain != DRAIN_W'(DRAIN_TIMEOUT_CYCLES + 1))) begin
            r_drain <= r_drain + DRAIN_W'(1);
        end
    end

    // Sticky force cause, cleared when software re-couples
    always_ff @(posedge aclk) begin
        if (!aresetn || w_leave_forced) r_force_cause <= 2'b00;
        else                            r_force_cause <= r_force_cause | w_cause_set;
    end

    // One-cycle irq mask after leaving FORCED
    always_ff @(posedge aclk) begin
        if (!aresetn) r_irq_mask <= 1'b0;
        else          r_irq_mask <= w_leave_forced;
    end

    assign o_bresp_expected = (r_aw_cnt != '0) && (r_w_cnt != '0);
    assign o_rresp_expected = (r_ar_cnt != '0);
    assign o_ctrl_state     = r_state;
    assign o_force_cause    = r_force_cause;
    assign o_aw_cnt         = r_aw_cnt;
    assign o_w_cnt          = r_w_cnt;
    assign o_ar_cnt         = r_ar_cnt;

endmodule

// File: tb/tb_axi_lite_isolation_controller.sv
// Scoreboard bench for axi_lite_isolation_controller: directed scenarios then
// randomized traffic, checked against a behavioural model.
module tb_axi_lite_isolation_controller;

    localparam int WMAX = 8;
    localparam int RMAX = 8;
    localparam int DTO  = 255;

    localparam bit [4:0] H_AW = 5'b10000;
    localparam bit [4:0] H_W  = 5'b01000;
    localparam bit [4:0] H_B  = 5'b00100;
    localparam bit [4:0] H_AR = 5'b00010;
    localparam bit [4:0] H_R  = 5'b00001;

    logic aclk = 1'b0;
    logic aresetn;
    logic awv, awr, wv, wr, bv, br, arv, arr, rv, rr;
    logic req, rec, irq;
    logic clr, baw, bw, bar, dec, frc, done, bresp, rresp;
    logic [1:0] st, cause;
    logic [3:0] awc, wc, arc;

    always #5 aclk = ~aclk;

    axi_lite_isolation_controller dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_mon_awvalid(awv), .i_mon_awready(awr),
        .i_mon_wvalid(wv),   .i_mon_wready(wr),
        .i_mon_bvalid(bv),   .i_mon_bready(br),
        .i_mon_arvalid(arv), .i_mon_arready(arr),
        .i_mon_rvalid(rv),   .i_mon_rready(rr),
        .i_sw_decouple_req(req), .i_sw_recouple(rec), .i_timeout_error_irq(irq),
        .o_timeout_error_clear(clr),
        .o_block_aw(baw), .o_block_w(bw), .o_block_ar(bar),
        .o_decouple(dec), .o_decouple_force(frc), .o_decouple_done(done),
        .o_bresp_expected(bresp), .o_rresp_expected(rresp),
        .o_ctrl_state(st), .o_force_cause(cause),
        .o_aw_cnt(awc), .o_w_cnt(wc), .o_ar_cnt(arc)
    );

    typedef struct {
        int st, cause, aw, w, ar;
        int baw, bw, bar, dec, frc, done, bresp, rresp, clr;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_push  = 0;
    int n_pop   = 0;

    // Behavioural model: mode name, outstanding counts, DRAINING cycles spent
    int  m_mode;            // 0 coupled, 1 draining, 2 decoupled, 3 forced
    int  m_aw, m_w, m_ar;
    int  m_drain_spent;
    int  m_cause;
    bit  m_irq_deaf;

    task automatic model_reset();
        m_mode = 0; m_aw = 0; m_w = 0; m_ar = 0;
        m_drain_spent = 0; m_cause = 0; m_irq_deaf = 0;
    endtask

    function automatic bit [2:0] model_blocks();
        case (m_mode)
            0: return {m_aw == WMAX, m_w == WMAX, m_ar == RMAX};
            1: return {m_aw >= m_w, m_w >= m_aw, 1'b1};
            default: return 3'b111;
        endcase
    endfunction

    function automatic int bump(int c, bit up, bit down, int max);
        if (up == down) return c;
        if (up) return (c == max) ? c : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic model_advance(bit [4:0] hs, bit r, bit rc, bit ir, bit rst_n);
        int  nxt;
        bit  alarm;
        if (!rst_n) begin
            model_reset();
            return;
        end
        alarm = ir && !m_irq_deaf;
        nxt = m_mode;
        if (m_mode == 3) begin
            if (rc) nxt = r ? 2 : 0;
        end else if (alarm) begin
            nxt = 3;
            m_cause = m_cause | 1;
        end else if (m_mode == 0) begin
            if (r) begin nxt = 1; m_drain_spent = 0; end
        end else if (m_mode == 1) begin
            if (m_aw == 0 && m_w == 0 && m_ar == 0) nxt = 2;
            else if (m_drain_spent == DTO) begin nxt = 3; m_cause = m_cause | 2; end
            m_drain_spent++;
        end else begin
            if (!r) nxt = 0;
        end
        if (nxt == 3 || m_mode == 3) begin
            m_aw = 0; m_w = 0; m_ar = 0;
        end else begin
            m_aw = bump(m_aw, hs[4], hs[2], WMAX);
            m_w  = bump(m_w,  hs[3], hs[2], WMAX);
            m_ar = bump(m_ar, hs[1], hs[0], RMAX);
        end
        m_irq_deaf = (m_mode == 3) && (nxt != 3);
        if (m_irq_deaf) m_cause = 0;
        m_mode = nxt;
    endtask

    task automatic drive_ch(input bit hs, output logic v, output logic r);
        int k;
        if (hs) begin v = 1'b1; r = 1'b1; end
        else begin
            k = $urandom_range(0, 2);
            v = (k == 1); r = (k == 2);
        end
    endtask

    // One cycle: drive inputs, push the model's expectation, advance model
    task automatic step(bit [4:0] hs, bit r, bit rc, bit ir, bit rst_n = 1'b1);
        exp_t e;
        bit [2:0] b;
        @(negedge aclk);
        drive_ch(hs[4], awv, awr);
        drive_ch(hs[3], wv, wr);
        drive_ch(hs[2], bv, br);
        drive_ch(hs[1], arv, arr);
        drive_ch(hs[0], rv, rr);
        req = r; rec = rc; irq = ir; aresetn = rst_n;
        b = model_blocks();
        e.st = m_mode; e.cause = m_cause; e.aw = m_aw; e.w = m_w; e.ar = m_ar;
        e.baw = b[2]; e.bw = b[1]; e.bar = b[0];
        e.dec = (m_mode != 0); e.frc = (m_mode == 3); e.done = (m_mode == 2);
        e.bresp = (m_aw != 0 && m_w != 0); e.rresp = (m_ar != 0);
        e.clr = rst_n && (m_mode == 3) && rc;
        q.push_back(e);
        n_push++;
        model_advance(hs, r, rc, ir, rst_n);
    endtask

    task automatic chk(string name, int act, int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_pop++;
                chk("ctrl_state", int'(st), e.st);
                chk("force_cause", int'(cause), e.cause);
                chk("aw_cnt", int'(awc), e.aw);
                chk("w_cnt", int'(wc), e.w);
                chk("ar_cnt", int'(arc), e.ar);
                chk("block_aw", int'(baw), e.baw);
                chk("block_w", int'(bw), e.bw);
                chk("block_ar", int'(bar), e.bar);
                chk("decouple", int'(dec), e.dec);
                chk("decouple_force", int'(frc), e.frc);
                chk("decouple_done", int'(done), e.done);
                chk("bresp_expected", int'(bresp), e.bresp);
                chk("rresp_expected", int'(rresp), e.rresp);
                chk("timeout_error_clear", int'(clr), e.clr);
            end
        end
    end

    initial begin
        bit [4:0] hs;
        bit [2:0] b;
        bit r;
        aresetn = 1'b0;
        {awv, awr, wv, wr, bv, br, arv, arr, rv, rr} = '0;
        req = 0; rec = 0; irq = 0;
        repeat (3) @(negedge aclk);
        model_reset();

        // Clean decouple with nothing outstanding, then release
        repeat (3) step(5'b0, 1, 0, 0);
        repeat (2) step(5'b0, 0, 0, 0);

        // Drain with an unpaired write pending
        step(H_AW | H_W, 0, 0, 0);
        step(H_AW, 0, 0, 0);
        step(5'b0, 1, 0, 0);
        step(H_W, 1, 0, 0);
        step(H_B, 1, 0, 0);
        step(H_B, 1, 0, 0);
        repeat (2) step(5'b0, 1, 0, 0);
        repeat (2) step(5'b0, 0, 0, 0);

        // Drain stalls on a withheld read response
        step(H_AR, 0, 0, 0);
        repeat (262) step(5'b0, 1, 0, 0);
        step(5'b0, 0, 1, 0);
        step(5'b0, 0, 0, 1);
        step(5'b0, 0, 0, 0);

        // Verifier timeout while coupled, late B, recover into DECOUPLED
        repeat (3) step(H_AW, 0, 0, 0);
        step(5'b0, 0, 0, 1);
        step(H_B, 0, 0, 1);
        step(5'b0, 1, 1, 1);
        step(5'b0, 1, 0, 1);
        step(5'b0, 0, 0, 0);
        step(5'b0, 0, 0, 0);

        // Read saturation and simultaneous AR/R
        repeat (9) step(H_AR, 0, 0, 0);
        step(H_AR | H_R, 0, 0, 0);
        step(H_R, 0, 0, 0);
        repeat (8) step(H_R, 0, 0, 0);

        // Reset mid-operation while FORCED with a recouple asserted
        step(H_AW, 0, 0, 1);
        step(5'b0, 0, 1, 0, 1'b0);
        step(5'b0, 0, 0, 0);

        // Randomized traffic obeying the model's gating
        r = 0;
        for (int i = 0; i < 3000; i++) begin
            b = model_blocks();
            if ($urandom_range(0, 39) == 0) r = ~r;
            hs = '0;
            hs[4] = !b[2] && ($urandom_range(0, 2) == 0);
            hs[3] = !b[1] && ($urandom_range(0, 2) == 0);
            hs[2] = ($urandom_range(0, 3) == 0);
            hs[1] = !b[0] && ($urandom_range(0, 2) == 0);
            hs[0] = ($urandom_range(0, 3) == 0);
            step(hs, r, $urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 499) != 0);
        end

        @(negedge aclk);
        #4;
        chk("scoreboard_drained", n_pop, n_push);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
